// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and MEM/WB packing constants for pipeline stage registers
package pipe_pkg;

    // Occupancy-encoded state of the skid stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // MEM/WB bundle: {MemtoReg, RegWrite, ReadData[31:0], ALURes[31:0], Rd[4:0]}
    localparam int MEMWB_W        = 71;
    localparam int MEMWB_RD_LSB   = 0;
    localparam int MEMWB_RD_W     = 5;
    localparam int MEMWB_ALU_LSB  = 5;
    localparam int MEMWB_ALU_W    = 32;
    localparam int MEMWB_RDAT_LSB = 37;
    localparam int MEMWB_RDAT_W   = 32;
    localparam int MEMWB_REGW_BIT = 69;
    localparam int MEMWB_M2R_BIT  = 70;

    // Pack the MEM/WB fields into the flat payload carried by pipe_stage_skid
    function automatic logic [MEMWB_W-1:0] memwb_pack(
        input logic        mem_to_reg,
        input logic        reg_write,
        input logic [31:0] read_data,
        input logic [31:0] alu_res,
        input logic [4:0]  rd
    );
        return {mem_to_reg, reg_write, read_data, alu_res, rd};
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter with asynchronous active-high reset
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count up on inc, stick at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready stage register with 2-entry skid buffer and flush; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Degenerate widths leave an empty marker block behind in the elaborated hierarchy
    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_params
    end

    skid_state_t       state_q;
    skid_state_t       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; flush only kills validity, contents are left as-is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Next state and payload movement; flush overrides any transfer this cycle
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decode straight from the state flops, so in_ready never sees out_ready
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != FULL);
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data = main_q;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state_q != EMPTY);

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid with a queue scoreboard
module tb_pipe_stage_skid;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_stage_skid #(
        .DATA_W (W),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] outlog[$];
    int           m_stall = 0;
    int           m_flush = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        chk({tag, ":in_ready"},  64'(in_ready),  64'(mq.size() < 2));
        chk({tag, ":occupancy"}, 64'(occupancy), 64'(mq.size()));
        if (mq.size() > 0) chk({tag, ":out_data"}, 64'(out_data), 64'(mq[0]));
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ":stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, ":flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the scoreboard at the edge
    task automatic tick(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input string tag);
        bit of;
        bit inf;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs(tag);
        of  = (mq.size() > 0) && ordy;
        inf = iv && (mq.size() < 2);
        if (of) outlog.push_back(out_data);
        if ((mq.size() > 0) && !ordy && (m_stall < CNT_MAX)) m_stall++;
        if (fl && (mq.size() > 0) && (m_flush < CNT_MAX)) m_flush++;
        if (fl) begin
            mq.delete();
        end else begin
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    // Pulse rst between edges and check the asynchronous effect before the next edge
    task automatic mid_reset(input string tag);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        #1;
        chk({tag, ":out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ":in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ":occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, ":out_data"},  64'(out_data),  64'd0);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ":stall_cnt"}, 64'(stall_cnt), 64'd0);
        chk({tag, ":flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
        mq.delete();
        m_stall = 0;
        m_flush = 0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] first;
        logic [W-1:0] rnd;

        // Power-on reset
        #1;
        mid_reset("por");

        // Reset while FULL
        tick(1'b1, 16'h000A, 1'b0, 1'b0, "t1_push_a");
        tick(1'b1, 16'h000B, 1'b0, 1'b0, "t1_push_b");
        chk("t1_full_occ", 64'(occupancy), 64'd2);
        mid_reset("t1_rst");

        // Back-to-back streaming
        outlog.delete();
        for (int i = 1; i <= 8; i++) tick(1'b1, W'(i), 1'b1, 1'b0, "t2_stream");
        tick(1'b0, '0, 1'b1, 1'b0, "t2_drain");
        tick(1'b0, '0, 1'b1, 1'b0, "t2_idle");
        chk("t2_count", 64'(outlog.size()), 64'd8);
        for (int i = 0; i < outlog.size(); i++) chk("t2_order", 64'(outlog[i]), 64'(i + 1));

        // Backpressure: C waits upstream until the stage drains
        outlog.delete();
        tick(1'b1, 16'h000A, 1'b0, 1'b0, "t3_a");
        tick(1'b1, 16'h000B, 1'b0, 1'b0, "t3_b");
        tick(1'b1, 16'h000C, 1'b0, 1'b0, "t3_c_held");
        tick(1'b1, 16'h000C, 1'b1, 1'b0, "t3_rel0");
        tick(1'b1, 16'h000C, 1'b1, 1'b0, "t3_rel1");
        tick(1'b0, '0, 1'b1, 1'b0, "t3_rel2");
        tick(1'b0, '0, 1'b1, 1'b0, "t3_idle");
        chk("t3_count", 64'(outlog.size()), 64'd3);
        chk("t3_w0", 64'(outlog[0]), 64'h0A);
        chk("t3_w1", 64'(outlog[1]), 64'h0B);
        chk("t3_w2", 64'(outlog[2]), 64'h0C);

        // Flush while FULL with a simultaneous push
        outlog.delete();
        tick(1'b1, 16'h000A, 1'b0, 1'b0, "t4_a");
        tick(1'b1, 16'h000B, 1'b0, 1'b0, "t4_b");
        tick(1'b1, 16'h000C, 1'b0, 1'b1, "t4_flush");
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_occ", 64'(occupancy), 64'd0);
        tick(1'b0, '0, 1'b1, 1'b0, "t4_after0");
        tick(1'b0, '0, 1'b1, 1'b0, "t4_after1");
        chk("t4_nothing_out", 64'(outlog.size()), 64'd0);

        // Stability under backpressure with random input words
        first = W'($urandom);
        tick(1'b1, first, 1'b0, 1'b0, "t5_first");
        for (int i = 0; i < 5; i++) begin
            rnd = W'($urandom);
            tick(1'b1, rnd, 1'b0, 1'b0, "t5_hold");
            chk("t5_stable", 64'(out_data), 64'(first));
        end
        tick(1'b0, '0, 1'b1, 1'b0, "t5_drain0");
        tick(1'b0, '0, 1'b1, 1'b0, "t5_drain1");
        tick(1'b0, '0, 1'b1, 1'b0, "t5_drain2");

`ifdef PIPE_PERF_CNT_EN
        // Counter saturation and flush counting
        mid_reset("t6_rst");
        tick(1'b1, 16'h0055, 1'b0, 1'b0, "t6_push");
        for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0, 1'b0, "t6_stall");
        chk("t6_stall_sat", 64'(stall_cnt), 64'd15);
        tick(1'b0, '0, 1'b1, 1'b0, "t6_drain");
        tick(1'b0, '0, 1'b1, 1'b1, "t6_flush_empty");
        chk("t6_flush_empty", 64'(flush_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, W'(i + 1), 1'b0, 1'b0, "t6_fill");
            tick(1'b0, '0, 1'b0, 1'b1, "t6_flush");
        end
        chk("t6_flush_cnt", 64'(flush_cnt), 64'd3);
`endif

        tick(1'b0, '0, 1'b1, 1'b0, "final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
